// File: rtl/alu_op_scheduler_pkg.sv
// rtl/alu_op_scheduler_pkg.sv - shared types and constants for the ALU operation scheduler
package alu_op_scheduler_pkg;

    localparam int DEF_DATA_W = 4;  // operand width (a, b)
    localparam int DEF_SEL_W  = 4;  // opcode width (sel)
    localparam int DEF_RES_W  = 6;  // ALU result width (y)
    localparam int STATS_W    = 8;  // per-requester accept counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/alu_rr_arb2.sv
// rtl/alu_rr_arb2.sv - two-way combinational round-robin arbiter
//
// Ports:
//   valid0, valid1 : requests
//   enable         : arbitration allowed this cycle (no grant when low)
//   last_grant     : ID granted most recently (register owned by parent)
//   grant0, grant1 : one-hot grant
//   grant_id       : ID of the granted requester (meaningful when a grant is up)
module alu_rr_arb2
    import alu_op_scheduler_pkg::*;
(
    input  logic    valid0,
    input  logic    valid1,
    input  logic    enable,
    input  req_id_t last_grant,
    output logic    grant0,
    output logic    grant1,
    output req_id_t grant_id
);

    // A lone requester always wins; under contention the one not served last wins.
    assign grant0   = enable & valid0 & (~valid1 | last_grant);
    assign grant1   = enable & valid1 & (~valid0 | ~last_grant);
    assign grant_id = grant1;

endmodule

// File: rtl/alu_op_scheduler.sv
// rtl/alu_op_scheduler.sv - shares one combinational ALU between two requesters
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   req{0,1}_valid/ready       : request handshake (ready only to the IDLE winner)
//   req{0,1}_a/b/sel           : operands and opcode, sampled on the accept edge
//   alu_a/alu_b/alu_sel        : registered operands to the external ALU
//   alu_y                      : combinational ALU result
//   resp_valid/ready/id/y      : tagged response channel
//   op_cnt0/op_cnt1            : saturating accept counters, present only when
//                                ALU_OP_SCHEDULER_STATS_EN is defined
module alu_op_scheduler
    import alu_op_scheduler_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEL_W  = DEF_SEL_W,
    parameter int RES_W  = DEF_RES_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SEL_W-1:0]  req1_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [RES_W-1:0]  alu_y,
    output logic              resp_valid,
    output logic              resp_id,
    output logic [RES_W-1:0]  resp_y,
    input  logic              resp_ready
`ifdef ALU_OP_SCHEDULER_STATS_EN
    ,
    output logic [STATS_W-1:0] op_cnt0,
    output logic [STATS_W-1:0] op_cnt1
`endif
);

    state_t  state, state_nxt;
    req_id_t last_grant;
    req_id_t cur_id;
    logic    grant0, grant1;
    req_id_t grant_id;
    logic    accept;

    alu_rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .enable     (state == IDLE),
        .last_grant (last_grant),
        .grant0     (grant0),
        .grant1     (grant1),
        .grant_id   (grant_id)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    // A grant implies the matching valid, so a grant is already a handshake.
    assign accept     = grant0 | grant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            last_grant <= 1'b1;
            cur_id     <= 1'b0;
            resp_y     <= '0;
            resp_id    <= 1'b0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= grant1 ? req1_a   : req0_a;
                        alu_b      <= grant1 ? req1_b   : req0_b;
                        alu_sel    <= grant1 ? req1_sel : req0_sel;
                        cur_id     <= grant_id;
                        last_grant <= grant_id;
                    end
                end
                EXEC: begin
                    resp_y     <= alu_y;
                    resp_id    <= cur_id;
                    resp_valid <= 1'b1;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_OP_SCHEDULER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt0 <= '0;
            op_cnt1 <= '0;
        end else begin
            if (grant0 && (op_cnt0 != {STATS_W{1'b1}})) begin
                op_cnt0 <= op_cnt0 + STATS_W'(1);
            end
            if (grant1 && (op_cnt1 != {STATS_W{1'b1}})) begin
                op_cnt1 <= op_cnt1 + STATS_W'(1);
            end
        end
    end
`endif

endmodule
